puf_challenge_sched: RTL
========================

PUF_CHALLENGE_SCHED -- requirements
Module: puf_challenge_sched

Interface
REQ-001 Parameter ADDR_W, default 10, challenge BRAM address width.
REQ-002 Parameter DATA_W, default 32, challenge/response word width.
REQ-003 Parameter NUM_REPS, default 8, range 1..15, evaluations per challenge.
REQ-004 Parameter GAP_CYCLES, default 16, idle cycles between evaluations; 0 is legal.
REQ-005 Parameter TIMEOUT_CYCLES, default 4096, used only when the timeout feature is compiled in.
REQ-006 Port clk  in  1  single clock for all logic.
REQ-007 Port rst  in  1  reset, synchronous and active-high.
REQ-008 Port start  in  1  one-cycle request to run a campaign.
REQ-009 Port cfg_base  in  ADDR_W  first challenge address.
REQ-010 Port cfg_count  in  ADDR_W  number of challenges minus one.
REQ-011 Port cfg_data  in  DATA_W  challenge data word.
REQ-012 Port busy  out  1  campaign in progress.
REQ-013 Port done  out  1  one-cycle pulse when a campaign ends.
REQ-014 Port gen_enable  out  1  one-cycle trigger to the collision generator.
REQ-015 Port cha_addr / cha_data  out  ADDR_W / DATA_W  challenge presented to the generator.
REQ-016 Port available  in  1  generator result-valid strobe.
REQ-017 Port rsp_neg  in  DATA_W  generator response sampled on available.
REQ-018 Port rsp_valid / rsp_ready  out / in  1  output handshake.
REQ-019 Port rsp_addr / rsp_word / rsp_unstable  out  ADDR_W / DATA_W / DATA_W  challenge address, majority response, and instability mask.
REQ-020 Port timeout_err  out  1  sticky timeout flag; held at 0 when the feature is off.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT_AVAIL, GAP, OUTPUT.
REQ-022 IDLE + start: latch cfg_*, clear the challenge index and rep counter, clear the accumulators, set busy, go to ISSUE. start SHALL be ignored while busy.
REQ-023 ISSUE: drive gen_enable high for exactly 1 cycle, then go to WAIT_AVAIL. cha_addr = (base + index) mod 2^ADDR_W; wrap is legal.
REQ-024 WAIT_AVAIL: on the cycle available=1, sample rsp_neg, update the per-bit ones counters, and increment the rep counter. available in any other state SHALL be ignored.
REQ-025 Instability mask: OR-accumulate (first sample XOR current sample); the first sample sets the reference and leaves the mask at 0.
REQ-026 Transitions after a sample:
- reps < NUM_REPS: go to GAP, then ISSUE after GAP_CYCLES cycles.
- Otherwise: go to OUTPUT.
- GAP_CYCLES=0: go directly to ISSUE.
REQ-027 Majority: bit = 1 iff 2*ones > NUM_REPS. A tie SHALL give 0.
REQ-028 OUTPUT: hold rsp_valid=1 and stable data until rsp_ready=1. rsp_ready may be high before valid.
REQ-029 On the handshake:
- If index == count: pulse done, clear busy, go to IDLE.
- Otherwise: increment index, clear the accumulators, go to ISSUE.
REQ-030 gen_enable SHALL never assert while rsp_valid=1. At most one generator request SHALL be outstanding.

Reset
REQ-031 rst SHALL return the block to IDLE from any state, including mid-campaign, within 1 cycle.
REQ-032 Reset values: busy, done, gen_enable, rsp_valid, timeout_err = 0; all data outputs and counters = 0.

Configuration
REQ-033 Macro PUF_SCHED_TIMEOUT_EN:
- Defined: WAIT_AVAIL counts cycles; after TIMEOUT_CYCLES without available, set timeout_err (sticky until rst), abandon the campaign, pulse done, return to IDLE with no rsp_valid.
- Undefined: no counter is built, WAIT_AVAIL waits indefinitely, timeout_err is tied to 0.

Structure
REQ-034 Package puf_pkg SHALL hold the FSM state encoding and the default ADDR_W, DATA_W, and NUM_REPS constants.
REQ-035 Sub-module puf_vote_acc SHALL hold the per-bit counters, majority compare, and instability mask, with clear/sample/result ports.

Verification
REQ-036 base=0, count=0, NUM_REPS=8, rsp_neg=0xA5A5A5A5 on every rep -> one output with word 0xA5A5A5A5, unstable=0, addr=0, then done; exactly 8 gen_enable pulses.
REQ-037 Rep values 0xFFFFFFFF x5 and 0x00000000 x3 -> word=0xFFFFFFFF, unstable=0xFFFFFFFF. With 4/4 -> word=0.
REQ-038 base=0x3FE, count=3 -> rsp_addr sequence 0x3FE, 0x3FF, 0x000, 0x001. With rsp_ready low 20 cycles -> data stable and no gen_enable.
REQ-039 rst asserted in WAIT_AVAIL of challenge 2 -> next cycle busy=0, rsp_valid=0. A new start runs cleanly from index 0.
REQ-040 With PUF_SCHED_TIMEOUT_EN and available withheld -> timeout_err=1 at cycle TIMEOUT_CYCLES, done pulse, no rsp_valid. start while busy -> ignored.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared constants and FSM encoding for the PUF challenge scheduler.
package puf_pkg;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REPS = 8;
  // Repetition counters are 4 bits wide because NUM_REPS never exceeds 15.
  localparam int REP_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_AVAIL,
    S_GAP,
    S_OUTPUT
  } sched_state_t;
endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit majority vote and instability mask over repeated PUF evaluations.
module puf_vote_acc
  import puf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REPS = DEF_NUM_REPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] unstable
);
  localparam logic [REP_W+1:0] REPS_X = (REP_W + 2)'(NUM_REPS);

  logic [REP_W-1:0]  ones [DATA_W];
  logic [DATA_W-1:0] ref_q;
  logic              have_ref;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DATA_W; i++) ones[i] <= '0;
      ref_q    <= '0;
      have_ref <= 1'b0;
      unstable <= '0;
    end else if (sample) begin
      for (int i = 0; i < DATA_W; i++) ones[i] <= ones[i] + REP_W'(din[i]);
      // The first sample becomes the reference; later ones flag any bit that differs from it.
      if (!have_ref) begin
        ref_q    <= din;
        have_ref <= 1'b1;
      end else begin
        unstable <= unstable | (ref_q ^ din);
      end
    end
  end

  // 2*ones > NUM_REPS, so a tie votes 0.
  always_comb begin
    word = '0;
    for (int i = 0; i < DATA_W; i++) word[i] = ({1'b0, ones[i], 1'b0} > REPS_X);
  end
endmodule

// File: rtl/puf_challenge_sched.sv
// Schedules repeated PUF challenge evaluations and emits majority-voted responses.
// Optional macro PUF_SCHED_TIMEOUT_EN adds a WAIT_AVAIL timeout with a sticky timeout_err.
module puf_challenge_sched
  import puf_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int NUM_REPS       = DEF_NUM_REPS,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              gen_enable,
  output logic [ADDR_W-1:0] cha_addr,
  output logic [DATA_W-1:0] cha_data,
  input  logic              available,
  input  logic [DATA_W-1:0] rsp_neg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_word,
  output logic [DATA_W-1:0] rsp_unstable,
  output logic              timeout_err
);
  // state        | meaning
  // S_IDLE       | waiting for start
  // S_ISSUE      | one-cycle gen_enable for the current challenge
  // S_WAIT_AVAIL | waiting for the generator's available strobe
  // S_GAP        | idle spacing between evaluations
  // S_OUTPUT     | holding the voted response until rsp_ready

  localparam int                GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit                GAP_EN   = (GAP_CYCLES > 0);

  sched_state_t      state, state_n;
  logic [ADDR_W-1:0] count_q, index_q, addr_q;
  logic [DATA_W-1:0] data_q;
  logic [REP_W-1:0]  rep_q;
  logic [GAP_W-1:0]  gap_q;
  logic              done_n, acc_clear, acc_sample, last_rep, to_expire;

  assign acc_sample = (state == S_WAIT_AVAIL) && available;
  assign last_rep   = (rep_q + 1'b1) >= REP_W'(NUM_REPS);

`ifdef PUF_SCHED_TIMEOUT_EN
  localparam int               TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q;
  logic            to_err_q;

  assign to_expire   = (state == S_WAIT_AVAIL) && !available && (to_q == '0);
  assign timeout_err = to_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE) to_q <= TO_LOAD;
      else if (state == S_WAIT_AVAIL && to_q != '0) to_q <= to_q - 1'b1;
      if (to_expire) to_err_q <= 1'b1;
    end
  end
`else
  assign to_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    gen_enable = 1'b0;
    acc_clear  = 1'b0;
    done_n     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n   = S_ISSUE;
        acc_clear = 1'b1;
      end
      S_ISSUE: begin
        gen_enable = 1'b1;
        state_n    = S_WAIT_AVAIL;
      end
      S_WAIT_AVAIL: begin
        if (available) begin
          if (last_rep)    state_n = S_OUTPUT;
          else if (GAP_EN) state_n = S_GAP;
          else             state_n = S_ISSUE;
        end else if (to_expire) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      S_GAP: if (gap_q == '0) state_n = S_ISSUE;
      S_OUTPUT: if (rsp_ready) begin
        if (index_q == count_q) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          state_n   = S_ISSUE;
          acc_clear = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        count_q <= cfg_count;
        index_q <= '0;
        addr_q  <= cfg_base;
        data_q  <= cfg_data;
        rep_q   <= '0;
      end
      if (acc_sample) begin
        rep_q <= rep_q + 1'b1;
        gap_q <= GAP_LOAD;
      end
      if (state == S_GAP && gap_q != '0) gap_q <= gap_q - 1'b1;
      // Address tracks base + index and wraps naturally at 2^ADDR_W.
      if (state == S_OUTPUT && rsp_ready && index_q != count_q) begin
        index_q <= index_q + 1'b1;
        addr_q  <= addr_q + 1'b1;
        rep_q   <= '0;
      end
    end
  end

  puf_vote_acc #(
    .DATA_W  (DATA_W),
    .NUM_REPS(NUM_REPS)
  ) u_vote (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc_clear),
    .sample  (acc_sample),
    .din     (rsp_neg),
    .word    (rsp_word),
    .unstable(rsp_unstable)
  );

  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_OUTPUT);
  assign cha_addr  = addr_q;
  assign cha_data  = data_q;
  assign rsp_addr  = addr_q;
endmodule
